// File: rtl/cell_fetch.sv
// Cell fetch unit: reads a tagged cell (tag + up to three payload words) from a
// 1-cycle synchronous ROM and presents it decoded on a valid/ready port.
// Optional one-entry last-cell cache enabled by `define CELL_FETCH_LAST_CACHE_EN.

package lisp;
    localparam logic [7:0] TYPE_NUMBER    = 8'h01;
    localparam logic [7:0] TYPE_CONS      = 8'h02;
    localparam logic [7:0] TYPE_FUNC_PRIM = 8'h03;
    localparam logic [7:0] TYPE_PRIM_CONS = 8'h21;
    localparam logic [7:0] NIL            = 8'h00;
endpackage

module cell_fetch #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  cell_valid,
    input  logic                  cell_ready,
    output logic [DATA_WIDTH-1:0] cell_tag,
    output logic [DATA_WIDTH-1:0] cell_f0,
    output logic [DATA_WIDTH-1:0] cell_f1,
    output logic [DATA_WIDTH-1:0] cell_f2,
    output logic [ADDR_WIDTH-1:0] cell_addr,
    output logic                  cell_err
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned NFLD_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NFLD_W-1:0]       nfld_q, nfld_d;
    logic                    req_ready_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic                    cell_valid_d;
    logic [DATA_WIDTH-1:0]   cell_tag_d, cell_f0_d, cell_f1_d, cell_f2_d;
    logic [ADDR_WIDTH-1:0]   cell_addr_d;
    logic                    cell_err_d;

`ifdef CELL_FETCH_LAST_CACHE_EN
    logic                    hit_q, hit_d;
    logic                    cache_vld_q, cache_vld_d;
    logic [ADDR_WIDTH-1:0]   cache_addr_q, cache_addr_d;
    logic [DATA_WIDTH-1:0]   cache_tag_q, cache_tag_d;
    logic [DATA_WIDTH-1:0]   cache_f0_q, cache_f0_d;
    logic [DATA_WIDTH-1:0]   cache_f1_q, cache_f1_d;
    logic [DATA_WIDTH-1:0]   cache_f2_q, cache_f2_d;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            idx_q      <= '0;
            nfld_q     <= '0;
            req_ready  <= 1'b1;
            mem_addr   <= '0;
            cell_valid <= 1'b0;
            cell_tag   <= '0;
            cell_f0    <= '0;
            cell_f1    <= '0;
            cell_f2    <= '0;
            cell_addr  <= '0;
            cell_err   <= 1'b0;
`ifdef CELL_FETCH_LAST_CACHE_EN
            hit_q        <= 1'b0;
            cache_vld_q  <= 1'b0;
            cache_addr_q <= '0;
            cache_tag_q  <= '0;
            cache_f0_q   <= '0;
            cache_f1_q   <= '0;
            cache_f2_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            nfld_q     <= nfld_d;
            req_ready  <= req_ready_d;
            mem_addr   <= mem_addr_d;
            cell_valid <= cell_valid_d;
            cell_tag   <= cell_tag_d;
            cell_f0    <= cell_f0_d;
            cell_f1    <= cell_f1_d;
            cell_f2    <= cell_f2_d;
            cell_addr  <= cell_addr_d;
            cell_err   <= cell_err_d;
`ifdef CELL_FETCH_LAST_CACHE_EN
            hit_q        <= hit_d;
            cache_vld_q  <= cache_vld_d;
            cache_addr_q <= cache_addr_d;
            cache_tag_q  <= cache_tag_d;
            cache_f0_q   <= cache_f0_d;
            cache_f1_q   <= cache_f1_d;
            cache_f2_q   <= cache_f2_d;
`endif
        end
    end

    // Next-state / next-output logic. idx_q counts FETCH edges since accept;
    // mem_data seen at an edge belongs to base+idx_q-1.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        idx_d       = idx_q;
        nfld_d      = nfld_q;
        mem_addr_d  = mem_addr;
        cell_tag_d  = cell_tag;
        cell_f0_d   = cell_f0;
        cell_f1_d   = cell_f1;
        cell_f2_d   = cell_f2;
        cell_addr_d = cell_addr;
        cell_err_d  = cell_err;
`ifdef CELL_FETCH_LAST_CACHE_EN
        hit_d        = hit_q;
        cache_vld_d  = cache_vld_q;
        cache_addr_d = cache_addr_q;
        cache_tag_d  = cache_tag_q;
        cache_f0_d   = cache_f0_q;
        cache_f1_d   = cache_f1_q;
        cache_f2_d   = cache_f2_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    base_d      = req_addr;
                    idx_d       = '0;
                    nfld_d      = '0;
                    cell_tag_d  = '0;
                    cell_f0_d   = '0;
                    cell_f1_d   = '0;
                    cell_f2_d   = '0;
                    cell_err_d  = 1'b0;
                    cell_addr_d = req_addr;
                    state_d     = FETCH;
`ifdef CELL_FETCH_LAST_CACHE_EN
                    if (cache_vld_q && (cache_addr_q == req_addr)) begin
                        hit_d = 1'b1;
                    end else begin
                        mem_addr_d = req_addr;
                    end
`else
                    mem_addr_d = req_addr;
`endif
                end
            end

            FETCH: begin
`ifdef CELL_FETCH_LAST_CACHE_EN
                if (hit_q) begin
                    hit_d      = 1'b0;
                    cell_tag_d = cache_tag_q;
                    cell_f0_d  = cache_f0_q;
                    cell_f1_d  = cache_f1_q;
                    cell_f2_d  = cache_f2_q;
                    state_d    = DONE;
                end else
`endif
                begin
                    idx_d      = idx_q + IDX_W'(1);
                    mem_addr_d = base_q + ADDR_WIDTH'(idx_q + IDX_W'(1));
                    if (idx_q == IDX_W'(1)) begin
                        cell_tag_d = mem_data;
                        if (mem_data == DATA_WIDTH'(lisp::TYPE_NUMBER)) begin
                            nfld_d = NFLD_W'(1);
                        end else if (mem_data == DATA_WIDTH'(lisp::TYPE_CONS)) begin
                            nfld_d = NFLD_W'(2);
                        end else if (mem_data == DATA_WIDTH'(lisp::TYPE_FUNC_PRIM)) begin
                            nfld_d = NFLD_W'(3);
                        end else begin
                            cell_err_d = 1'b1;
                            state_d    = DONE;
                        end
                    end else if (idx_q >= IDX_W'(2)) begin
                        if (idx_q == IDX_W'(2)) cell_f0_d = mem_data;
                        if (idx_q == IDX_W'(3)) cell_f1_d = mem_data;
                        if (idx_q == IDX_W'(4)) cell_f2_d = mem_data;
                        if (idx_q == (IDX_W'(nfld_q) + IDX_W'(1))) begin
                            state_d = DONE;
                        end
                    end
                end
            end

            DONE: begin
                if (cell_ready) begin
                    state_d = IDLE;
`ifdef CELL_FETCH_LAST_CACHE_EN
                    // Only successful decodes are remembered
                    if (!cell_err) begin
                        cache_vld_d  = 1'b1;
                        cache_addr_d = cell_addr;
                        cache_tag_d  = cell_tag;
                        cache_f0_d   = cell_f0;
                        cache_f1_d   = cell_f1;
                        cache_f2_d   = cell_f2;
                    end
`endif
                end
            end

            default: state_d = IDLE;
        endcase

        req_ready_d  = (state_d == IDLE);
        cell_valid_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_cell_fetch.sv
// Directed bench for cell_fetch: table of cell requests against a registered
// boot-image ROM model, plus wrap, reset-abort and repeat-request sequences.

module tb_cell_fetch;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       cell_valid;
    logic       cell_ready;
    logic [7:0] cell_tag;
    logic [7:0] cell_f0;
    logic [7:0] cell_f1;
    logic [7:0] cell_f2;
    logic [7:0] cell_addr;
    logic       cell_err;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:255];

    typedef struct {
        logic [7:0] addr;
        int         hold;
        int         lat;
        logic [7:0] tag;
        logic [7:0] f0;
        logic [7:0] f1;
        logic [7:0] f2;
        logic       err;
        logic       cached;
    } vec_t;

    cell_fetch #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cell_valid (cell_valid),
        .cell_ready (cell_ready),
        .cell_tag   (cell_tag),
        .cell_f0    (cell_f0),
        .cell_f1    (cell_f1),
        .cell_f2    (cell_f2),
        .cell_addr  (cell_addr),
        .cell_err   (cell_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) mem_data <= mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] addr, input int hold, input int lat,
                                input logic [7:0] tag, input logic [7:0] f0,
                                input logic [7:0] f1, input logic [7:0] f2,
                                input logic err, input logic cached);
        vec_t v;
        v.addr = addr; v.hold = hold; v.lat = lat; v.tag = tag;
        v.f0 = f0; v.f1 = f1; v.f2 = f2; v.err = err; v.cached = cached;
        return v;
    endfunction

    // One request: accept, count edges to cell_valid, check contents,
    // optionally stall the consumer, then check the return to IDLE.
    task automatic run_vec(input vec_t v);
        logic [7:0] ma [0:31];
        logic [7:0] prev_ma;
        logic [7:0] exp_a;
        int n;
        cell_ready = (v.hold == 0);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        prev_ma   = mem_addr;
        req_valid = 1'b1;
        req_addr  = v.addr;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 8'hAA;
        ma[0] = mem_addr;
        n = 0;
        while (!cell_valid && n < 20) begin
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            n++;
            ma[n] = mem_addr;
        end
        chk("latency", 32'(n), 32'(v.lat));
        for (int i = 0; i <= n && i < v.lat; i++) begin
            exp_a = v.cached ? prev_ma : 8'(v.addr + 8'(i));
            chk("mem_addr_seq", 32'(ma[i]), 32'(exp_a));
        end
        chk("cell_valid", 32'(cell_valid), 32'd1);
        chk("cell_tag",   32'(cell_tag),   32'(v.tag));
        chk("cell_f0",    32'(cell_f0),    32'(v.f0));
        chk("cell_f1",    32'(cell_f1),    32'(v.f1));
        chk("cell_f2",    32'(cell_f2),    32'(v.f2));
        chk("cell_addr",  32'(cell_addr),  32'(v.addr));
        chk("cell_err",   32'(cell_err),   32'(v.err));
        exp_a = mem_addr;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            req_valid = (h % 3 == 1);
            req_addr  = 8'h55;
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(cell_valid), 32'd1);
            chk("hold_ready", 32'(req_ready),  32'd0);
            chk("hold_tag",   32'(cell_tag),   32'(v.tag));
            chk("hold_f0",    32'(cell_f0),    32'(v.f0));
            chk("hold_f1",    32'(cell_f1),    32'(v.f1));
            chk("hold_f2",    32'(cell_f2),    32'(v.f2));
            chk("hold_addr",  32'(cell_addr),  32'(v.addr));
            chk("hold_err",   32'(cell_err),   32'(v.err));
            chk("hold_mem_addr", 32'(mem_addr), 32'(exp_a));
        end
        if (v.hold > 0) begin
            @(negedge clk);
            req_valid  = 1'b0;
            cell_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("idle_valid", 32'(cell_valid), 32'd0);
        chk("idle_ready", 32'(req_ready),  32'd1);
    endtask

    vec_t tbl [5];
    vec_t v;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = lisp::TYPE_NUMBER;    mem[8'h01] = 8'h12;
        mem[8'h04] = lisp::TYPE_FUNC_PRIM; mem[8'h05] = lisp::TYPE_PRIM_CONS;
        mem[8'h06] = lisp::NIL;            mem[8'h07] = lisp::NIL;
        mem[8'h08] = lisp::TYPE_CONS;      mem[8'h09] = 8'h02; mem[8'h0A] = lisp::NIL;
        mem[8'h0E] = lisp::TYPE_CONS;      mem[8'h0F] = 8'h04; mem[8'h10] = 8'h0B;
        mem[8'h30] = 8'hFF;
        mem[8'hFE] = lisp::TYPE_CONS;      mem[8'hFF] = 8'h11;

        tbl[0] = mk(8'h00, 0,  3, lisp::TYPE_NUMBER, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0);
        tbl[1] = mk(8'h08, 0,  4, lisp::TYPE_CONS, 8'h02, lisp::NIL, 8'h00, 1'b0, 1'b0);
        tbl[2] = mk(8'h0E, 0,  4, lisp::TYPE_CONS, 8'h04, 8'h0B, 8'h00, 1'b0, 1'b0);
        tbl[3] = mk(8'h04, 10, 5, lisp::TYPE_FUNC_PRIM, lisp::TYPE_PRIM_CONS,
                    lisp::NIL, lisp::NIL, 1'b0, 1'b0);
        tbl[4] = mk(8'h30, 0,  2, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 8'h00;
        cell_ready = 1'b1;
        #12;
        chk("rst_req_ready",  32'(req_ready),  32'd1);
        chk("rst_cell_valid", 32'(cell_valid), 32'd0);
        chk("rst_mem_addr",   32'(mem_addr),   32'd0);
        chk("rst_cell_err",   32'(cell_err),   32'd0);
        chk("rst_cell_tag",   32'(cell_tag),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Cell straddling the top of the address space
        mem[8'h00] = 8'h22;
        run_vec(mk(8'hFE, 0, 4, lisp::TYPE_CONS, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0));
        mem[8'h00] = lisp::TYPE_NUMBER;

        // Asynchronous reset in the middle of a FUNC_PRIM fetch
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 8'h04;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready",  32'(req_ready),  32'd1);
        chk("midrst_cell_valid", 32'(cell_valid), 32'd0);
        chk("midrst_mem_addr",   32'(mem_addr),   32'd0);
        chk("midrst_cell_tag",   32'(cell_tag),   32'd0);
        chk("midrst_cell_addr",  32'(cell_addr),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("postrst_no_cell", 32'(cell_valid), 32'd0);
        end

        run_vec(tbl[0]);
`ifdef CELL_FETCH_LAST_CACHE_EN
        v = mk(8'h00, 0, 1, lisp::TYPE_NUMBER, 8'h12, 8'h00, 8'h00, 1'b0, 1'b1);
`else
        v = mk(8'h00, 0, 3, lisp::TYPE_NUMBER, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0);
`endif
        run_vec(v);
        // A failed decode must not be served from the cache
        run_vec(tbl[4]);
        run_vec(tbl[4]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
